reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_scoreboard.sv | 42 ++++
 rtl/reg_file_mp.sv | 93 +++++++++
 tb/tb_reg_file_mp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and sizing helper for the multi-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Number of registers addressed by an aw-bit address.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue,
// cleared on load writeback. Lookups see the post-update value so a read
// issued in the same cycle as a set/clear observes its effect.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_set_en,
  input  logic [ADDR_W-1:0]          i_set_addr,
  input  logic                       i_clr_en,
  input  logic [ADDR_W-1:0]          i_clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   i_lookup_addr,
  output logic [NUM_RD-1:0]          o_lookup_busy
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clear before set so a simultaneous set/clear of one address leaves it set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Busy state register; reset drops every pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
    assign o_lookup_busy[p] = w_busy_nxt[i_lookup_addr[p*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with two write ports, write-through bypass
// and a load scoreboard. Read data and busy are registered (1-cycle latency)
// and hold while the port's read enable is low.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       busy_set_en,
  input  logic [ADDR_W-1:0]          busy_set_addr
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
  logic [NUM_RD-1:0][DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]             r_rd_busy;
  logic [NUM_RD-1:0]             w_lookup_busy;
  logic                          w_wr0_ok;
  logic                          w_wr1_ok;

  // Writes to the hardwired zero register are dropped at the source.
  assign w_wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign w_wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

  // Storage; wr0 is applied last so it wins an address collision with wr1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else begin
      if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
      if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_set_en      (busy_set_en),
    .i_set_addr    (busy_set_addr),
    .i_clr_en      (wr1_en),
    .i_clr_addr    (wr1_addr),
    .i_lookup_addr (rd_addr),
    .o_lookup_busy (w_lookup_busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Bypass same-cycle writes, wr0 over wr1; zero register reads as 0.
    always_comb begin
      w_rdata = r_mem[w_addr];
      if (w_wr1_ok && (wr1_addr == w_addr)) w_rdata = wr1_data;
      if (w_wr0_ok && (wr0_addr == w_addr)) w_rdata = wr0_data;
      if ((ZERO_REG != 0) && (w_addr == '0)) w_rdata = '0;
    end

    // Read output register, loaded only when the port is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data[p] <= '0;
        r_rd_busy[p] <= 1'b0;
      end else if (rd_en[p]) begin
        r_rd_data[p] <= w_rdata;
        r_rd_busy[p] <= w_lookup_busy[p];
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (zero register on / off) share all
// inputs; directed scenarios plus randomized traffic against a sequential model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_z, rd_data_n;
  logic [NR-1:0]   rd_busy_z, rd_busy_n;
  logic            wr0_en, wr1_en, busy_set_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, busy_set_addr;
  logic [DW-1:0]   wr0_data, wr1_data;

  int checks = 0;
  int failures = 0;

  // Model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
  logic [DW-1:0]    m_mem  [2][32];
  logic             m_busy [2][32];
  logic [NR*DW-1:0] m_rd   [2];
  logic [NR-1:0]    m_rb   [2];

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[d][a]  = '0;
        m_busy[d][a] = 1'b0;
      end
      m_rd[d] = '0;
      m_rb[d] = '0;
    end
  endtask

  // One clock of architectural behaviour: apply writes and busy changes in
  // program order, then enabled ports read the resulting state.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit zr = (d == 0);
      if (wr1_en && !(zr && wr1_addr == 0)) m_mem[d][wr1_addr] = wr1_data;
      if (wr0_en && !(zr && wr0_addr == 0)) m_mem[d][wr0_addr] = wr0_data;
      if (wr1_en) m_busy[d][wr1_addr] = 1'b0;
      if (busy_set_en && !(zr && busy_set_addr == 0)) m_busy[d][busy_set_addr] = 1'b1;
      for (int p = 0; p < NR; p++) begin
        if (rd_en[p]) begin
          m_rd[d][p*DW +: DW] = m_mem[d][rd_addr[p*AW +: AW]];
          m_rb[d][p]          = m_busy[d][rd_addr[p*AW +: AW]];
        end
      end
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    busy_set_en = 0; busy_set_addr = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++; if (rd_data_z !== '0) begin failures++; $display("FAIL reset_init data_z got=%h want=0", rd_data_z); end
    checks++; if (rd_busy_n !== '0) begin failures++; $display("FAIL reset_init busy_n got=%h want=0", rd_busy_n); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr0_en = 1; wr0_addr = AW'($urandom_range(1, 31)); wr0_data = $urandom;
      busy_set_en = 1; busy_set_addr = AW'($urandom_range(0, 31));
      rd(i % NR, AW'($urandom_range(0, 31)));
      tick();
    end
    // Assert reset between edges and observe outputs clear without a clock.
    #1; rst_n = 1'b0; model_reset(); #1;
    checks++; if (rd_data_z !== '0 || rd_busy_z !== '0) begin failures++; $display("FAIL reset_async z data=%h busy=%h want=0", rd_data_z, rd_busy_z); end
    checks++; if (rd_data_n !== '0 || rd_busy_n !== '0) begin failures++; $display("FAIL reset_async n data=%h busy=%h want=0", rd_data_n, rd_busy_n); end
    // Traffic presented during reset must be discarded.
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h1234_5678;
    busy_set_en = 1; busy_set_addr = 3;
    for (int p = 0; p < NR; p++) rd(p, 3);
    tick(); tick();
    checks++; if (rd_data_n !== '0 || rd_busy_n !== '0) begin failures++; $display("FAIL reset_hold n data=%h busy=%h want=0", rd_data_n, rd_busy_n); end
    @(negedge clk); rst_n = 1'b1; idle();
    for (int a = 0; a < 32; a += NR) begin
      for (int p = 0; p < NR; p++) rd(p, AW'(a + p));
      tick();
      checks++; if (rd_data_z !== '0 || rd_busy_z !== '0) begin failures++; $display("FAIL reset_clear z base=%0d data=%h busy=%h want=0", a, rd_data_z, rd_busy_z); end
      checks++; if (rd_data_n !== '0 || rd_busy_n !== '0) begin failures++; $display("FAIL reset_clear n base=%0d data=%h busy=%h want=0", a, rd_data_n, rd_busy_n); end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    rd(1, 5);
    tick();
    checks++; if (rd_data_z[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass z got=%h want=deadbeef", rd_data_z[63:32]); end
    checks++; if (rd_data_n[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass n got=%h want=deadbeef", rd_data_n[63:32]); end
    // wr0 beats wr1 on the bypass path too.
    idle();
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'hAAAA_0001;
    wr1_en = 1; wr1_addr = 12; wr1_data = 32'hBBBB_0002;
    rd(2, 12);
    tick();
    checks++; if (rd_data_z[95:64] !== 32'hAAAA_0001) begin failures++; $display("FAIL bypass_prio got=%h want=aaaa0001", rd_data_z[95:64]); end
    idle();
  endtask

  task automatic test_collision();
    idle();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    tick();
    idle(); rd(0, 7);
    tick();
    checks++; if (rd_data_z[31:0] !== 32'h11) begin failures++; $display("FAIL collision z got=%h want=11", rd_data_z[31:0]); end
    checks++; if (rd_data_n[31:0] !== 32'h11) begin failures++; $display("FAIL collision n got=%h want=11", rd_data_n[31:0]); end
    idle();
  endtask

  task automatic test_zero();
    idle();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h55;
    busy_set_en = 1; busy_set_addr = 0;
    tick();
    idle(); rd(2, 0);
    tick();
    checks++; if (rd_data_z[95:64] !== 32'h0 || rd_busy_z[2] !== 1'b0) begin failures++; $display("FAIL zero_on data=%h busy=%b want=0/0", rd_data_z[95:64], rd_busy_z[2]); end
    checks++; if (rd_data_n[95:64] !== 32'h55 || rd_busy_n[2] !== 1'b1) begin failures++; $display("FAIL zero_off data=%h busy=%b want=55/1", rd_data_n[95:64], rd_busy_n[2]); end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    busy_set_en = 1; busy_set_addr = 9;
    tick();
    idle(); rd(3, 9);
    tick();
    checks++; if (rd_busy_z[3] !== 1'b1 || rd_busy_n[3] !== 1'b1) begin failures++; $display("FAIL sb_set busy_z=%b busy_n=%b want=1", rd_busy_z[3], rd_busy_n[3]); end
    idle();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h9999;
    busy_set_en = 1; busy_set_addr = 9;
    rd(3, 9);
    tick();
    checks++; if (rd_busy_z[3] !== 1'b1) begin failures++; $display("FAIL sb_setclr busy=%b want=1", rd_busy_z[3]); end
    idle();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h7777;
    rd(3, 9);
    tick();
    checks++; if (rd_busy_z[3] !== 1'b0 || rd_busy_n[3] !== 1'b0) begin failures++; $display("FAIL sb_clr busy_z=%b busy_n=%b want=0", rd_busy_z[3], rd_busy_n[3]); end
    checks++; if (rd_data_z[127:96] !== 32'h7777) begin failures++; $display("FAIL sb_clr_data got=%h want=7777", rd_data_z[127:96]); end
    // wr0 does not clear a pending load.
    idle(); busy_set_en = 1; busy_set_addr = 10; tick();
    idle(); wr0_en = 1; wr0_addr = 10; wr0_data = 32'h1; rd(0, 10); tick();
    checks++; if (rd_busy_z[0] !== 1'b1) begin failures++; $display("FAIL sb_wr0 busy=%b want=1", rd_busy_z[0]); end
    idle();
  endtask

  task automatic test_multiport();
    idle();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5A5;
    tick();
    idle();
    for (int p = 0; p < NR; p++) rd(p, 3);
    tick();
    for (int p = 0; p < NR; p++) begin
      checks++; if (rd_data_z[p*DW +: DW] !== 32'hA5A5) begin failures++; $display("FAIL multiport z port=%0d got=%h want=a5a5", p, rd_data_z[p*DW +: DW]); end
      checks++; if (rd_data_n[p*DW +: DW] !== 32'hA5A5) begin failures++; $display("FAIL multiport n port=%0d got=%h want=a5a5", p, rd_data_n[p*DW +: DW]); end
    end
    // Ports disabled: outputs hold the previous reads.
    idle(); wr0_en = 1; wr0_addr = 3; wr0_data = 32'h0BAD; tick();
    checks++; if (rd_data_z[31:0] !== 32'hA5A5) begin failures++; $display("FAIL hold got=%h want=a5a5", rd_data_z[31:0]); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_en = NR'($urandom);
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = AW'(($urandom % 2) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wr0_en = ($urandom % 3) != 0; wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = ($urandom % 3) == 0; wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
      busy_set_en = ($urandom % 2) != 0; busy_set_addr = AW'($urandom_range(0, 7));
      tick();
      checks++; if (rd_data_z !== m_rd[0] || rd_busy_z !== m_rb[0]) begin failures++; $display("FAIL random z cyc=%0d data=%h busy=%h want=%h/%h", i, rd_data_z, rd_busy_z, m_rd[0], m_rb[0]); end
      checks++; if (rd_data_n !== m_rd[1] || rd_busy_n !== m_rb[1]) begin failures++; $display("FAIL random n cyc=%0d data=%h busy=%h want=%h/%h", i, rd_data_n, rd_busy_n, m_rd[1], m_rb[1]); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_zero();
    test_scoreboard();
    test_multiport();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
